// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder: opcode encodings and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LAT   = 2;

endpackage : adder_pkg

// File: rtl/adder_stage.sv
// One enabled pipeline register holding a result slot (valid, sum, cout, ovf).
// Latency: 1 cycle when en is high; holds its contents while en is low.
// Backpressure: none of its own; the shared en from the top stalls every stage together.
// Ports: clk/rst_n (sync active-low), en, d_* slot in, q_* slot out.
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_sum,
  input  logic             d_cout,
  input  logic             d_ovf,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_sum,
  output logic             q_cout,
  output logic             q_ovf
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_sum   <= '0;
      q_cout  <= 1'b0;
      q_ovf   <= 1'b0;
    end else if (en) begin
      // Bubbles move through as invalid slots; they are never squeezed out.
      q_valid <= d_valid;
      q_sum   <= d_sum;
      q_cout  <= d_cout;
      q_ovf   <= d_ovf;
    end
  end

endmodule : adder_stage

// File: rtl/pipe_adder.sv
// Pipelined unsigned add/subtract with carry, signed-overflow flag and optional saturation.
// Latency: LAT cycles from accept to out_valid (compute register plus LAT-1 adder_stage slots).
// Backpressure: single global enable en = !out_valid || out_ready stalls the whole pipe; in_ready = en.
// Ports: in_valid/in_ready/a/b/op upstream; out_valid/out_ready/sum/cout/ovf downstream;
//        txn_cnt counts delivered results (16-bit, wraps).
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = DEF_LAT,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [15:0]      txn_cnt
);

  localparam int MSB = WIDTH - 1;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------------------
  // Compute: one WIDTH+1 bit adder serves both ops; subtract is a + ~b + 1,
  // so the top bit is carry for add and not-borrow (a >= b) for subtract.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   raw;
  logic             raw_cout;
  logic             raw_ovf;
  logic [WIDTH-1:0] res_sum;

  always_comb begin
    b_eff    = (op == OP_SUB) ? ~b : b;
    raw      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op};
    raw_cout = raw[WIDTH];
    if (op == OP_SUB) begin
      raw_ovf = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);
    end else begin
      raw_ovf = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
    end

    // Saturation only clamps the sum; cout/ovf keep describing the raw result.
    res_sum = raw[WIDTH-1:0];
    if (SAT != 0) begin
      if ((op == OP_ADD) && raw_cout) begin
        res_sum = '1;
      end else if ((op == OP_SUB) && !raw_cout) begin
        res_sum = '0;
      end
    end
  end

  // Pipeline slot wires: index 0 is the compute register, LAT-1 is the output.
  logic             pv [LAT];
  logic [WIDTH-1:0] ps [LAT];
  logic             pc [LAT];
  logic             po [LAT];

  logic             s0_valid;
  logic [WIDTH-1:0] s0_sum;
  logic             s0_cout;
  logic             s0_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_sum   <= '0;
      s0_cout  <= 1'b0;
      s0_ovf   <= 1'b0;
    end else if (en) begin
      s0_valid <= in_valid;
      s0_sum   <= res_sum;
      s0_cout  <= raw_cout;
      s0_ovf   <= raw_ovf;
    end
  end

  assign pv[0] = s0_valid;
  assign ps[0] = s0_sum;
  assign pc[0] = s0_cout;
  assign po[0] = s0_ovf;

  for (genvar i = 1; i < LAT; i++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .d_valid (pv[i-1]),
      .d_sum   (ps[i-1]),
      .d_cout  (pc[i-1]),
      .d_ovf   (po[i-1]),
      .q_valid (pv[i]),
      .q_sum   (ps[i]),
      .q_cout  (pc[i]),
      .q_ovf   (po[i])
    );
  end

  assign out_valid = pv[LAT-1];
  assign sum       = ps[LAT-1];
  assign cout      = pc[LAT-1];
  assign ovf       = po[LAT-1];

  // Delivered-result counter; natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_cnt <= 16'h0000;
    end else if (out_valid && out_ready) begin
      txn_cnt <= txn_cnt + 16'h0001;
    end
  end

endmodule : pipe_adder

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: a wrapping (SAT=0) and a saturating (SAT=1) instance share stimulus.
// Expected results are queued at accept time and popped by an independent output monitor.
// Directed vectors carry hand-computed results for both instances.
module tb_pipe_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic       op;
  logic       ordy;

  logic       ir0, ov0, c0, o0;
  logic [7:0] s0;
  logic [15:0] t0;
  logic       ir1, ov1, c1, o1;
  logic [7:0] s1;
  logic [15:0] t1;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(8), .LAT(2), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b), .op(op), .out_valid(ov0), .out_ready(ordy),
    .sum(s0), .cout(c0), .ovf(o0), .txn_cnt(t0)
  );

  pipe_adder #(.WIDTH(8), .LAT(2), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .op(op), .out_valid(ov1), .out_ready(ordy),
    .sum(s1), .cout(c1), .ovf(o1), .txn_cnt(t1)
  );

  typedef struct {
    logic [7:0] e0;
    logic [7:0] e1;
    logic       ec;
    logic       eo;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  bit   tog_en = 1'b0;
  int   tcnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output monitor: pop on delivery, compare against queue head while stalled.
  always @(negedge clk) begin
    if (mon_en && ov0) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {31'b0, ov0}, 32'd0);
      end else begin
        chk("sum_wrap", {24'b0, s0}, {24'b0, sb[0].e0});
        chk("cout_wrap", {31'b0, c0}, {31'b0, sb[0].ec});
        chk("ovf_wrap", {31'b0, o0}, {31'b0, sb[0].eo});
        chk("valid_sat", {31'b0, ov1}, 32'd1);
        chk("sum_sat", {24'b0, s1}, {24'b0, sb[0].e1});
        chk("cout_sat", {31'b0, c1}, {31'b0, sb[0].ec});
        chk("ovf_sat", {31'b0, o1}, {31'b0, sb[0].eo});
        if (ordy) begin
          if (sb[0].lat) chk("latency", cyc - sb[0].acc, 32'd2);
          void'(sb.pop_front());
        end
      end
    end
  end

  // out_ready toggles every third cycle while streaming.
  always begin
    @(posedge clk);
    #1;
    if (tog_en) begin
      tcnt++;
      if (tcnt % 3 == 0) ordy = ~ordy;
    end
  end

  // Presents one operand set (called at posedge+1) and holds it until accepted.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic top,
                      input logic [7:0] e0, input logic [7:0] e1,
                      input logic ec, input logic eo, input bit lat);
    int  tries = 0;
    bit  done  = 1'b0;
    exp_t e;
    a = ta; b = tb; op = top; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (ir0) begin
        e.e0 = e0; e.e1 = e1; e.ec = ec; e.eo = eo; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        tries++;
        if (tries > 100) begin
          chk("send_timeout", tries, 32'd0);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", sb.size(), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, ir0}, 32'd1);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, ov0}, 32'd0);
    chk("rst_sum", {24'b0, s0}, 32'd0);
    chk("rst_cout", {31'b0, c0}, 32'd0);
    chk("rst_ovf", {31'b0, o0}, 32'd0);
    chk("rst_txn", {16'b0, t0}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed vectors, out_ready held high: latency checked on each.
    send(8'h05, 8'h03, 1'b0, 8'h08, 8'h08, 1'b0, 1'b0, 1'b1);
    send(8'hFF, 8'h01, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
    send(8'h80, 8'h01, 1'b1, 8'h7F, 8'h7F, 1'b1, 1'b1, 1'b1);
    send(8'h02, 8'h05, 1'b1, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b1);
    send(8'h7F, 8'h01, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1);
    send(8'h05, 8'h05, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    send(8'h80, 8'h80, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1);
    drain();
    chk("txn_directed", {16'b0, t0}, 32'd7);

    // Streaming with out_ready toggling every 3 cycles.
    pulse_reset();
    chk("txn_after_reset", {16'b0, t0}, 32'd0);
    tog_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send(i[7:0], i[7:0], 1'b0, 8'(2 * i), 8'(2 * i), 1'b0, 1'b0, 1'b0);
    end
    drain();
    tog_en = 1'b0;
    ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("txn_stream_wrap", {16'b0, t0}, 32'd25);
    chk("txn_stream_sat", {16'b0, t1}, 32'd25);

    // Reset mid-stall with two results in flight.
    pulse_reset();
    ordy = 1'b0;
    send(8'h01, 8'h02, 1'b0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0);
    send(8'h04, 8'h04, 1'b0, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_valid", {31'b0, ov0}, 32'd1);
    chk("stall_in_ready", {31'b0, ir0}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_valid_wrap", {31'b0, ov0}, 32'd0);
    chk("midrst_valid_sat", {31'b0, ov1}, 32'd0);
    chk("midrst_txn", {16'b0, t0}, 32'd0);
    ordy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_txn", {16'b0, t0}, 32'd0);
    chk("sb_left", sb.size(), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_adder
